// File: rtl/clock_port_bridge_if.sv
// Emulator-side handshake bundle for clock_port_bridge.
// Toggle protocol: master flips emu_req once per access and holds emu_rnw;
// slave completes by making emu_ack equal emu_req, with emu_rdata valid from then on.
interface clock_port_bridge_if #(
  parameter int DW = 4
);
  logic          emu_req;
  logic          emu_rnw;
  logic          emu_done;
  logic          emu_ack;
  logic [DW-1:0] emu_rdata;

  modport master (
    output emu_req, emu_rnw, emu_done,
    input  emu_ack, emu_rdata
  );

  modport slave (
    input  emu_req, emu_rnw, emu_done,
    output emu_ack, emu_rdata
  );
endinterface

// File: rtl/clock_port_bridge.sv
// Amiga clock-port front end: synchronises strobes, routes accesses to clock memory or emulator.
// Optional ack timeout enabled by defining CP_ACK_TIMEOUT_EN.
module clock_port_bridge #(
  parameter int                  AW             = 4,
  parameter int                  DW             = 4,
  parameter int                  SYNC_STAGES    = 2,
  parameter logic [(1<<AW)-1:0]  BYPASS_MASK    = 16'h2000,
  parameter int                  TIMEOUT_CYCLES = 1024,
  parameter logic [DW-1:0]       TIMEOUT_DATA   = '0
) (
  input  logic                clk200,
  input  logic                reset_n,
  input  logic                CP_RTC_CS_n,
  input  logic                CP_RD_n,
  input  logic                CP_WR_n,
  input  logic [AW-1:0]       CP_A,
  inout  wire  [DW-1:0]       CP_D,
  input  logic                cmem_bank,
  clock_port_bridge_if.master emu,
  output logic                cmem_rd,
  output logic                cmem_wr,
  input  logic [DW-1:0]       cmem_rdata,
  output logic [AW-1:0]       cp_address,
  output logic [DW-1:0]       cp_data_out,
  output logic [7:0]          timeout_count,
  output logic                cp_d_oe,
  output logic [2:0]          state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LATCH     = 3'd1,
    S_WAIT_EMU  = 3'd2,
    S_WAIT_CMEM = 3'd3
`ifdef CP_ACK_TIMEOUT_EN
    , S_TIMEDOUT = 3'd4
`endif
  } state_t;

`ifdef CP_ACK_TIMEOUT_EN
  localparam bit STALL_ON_PENDING = 1'b0;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic [7:0]    to_num_q, to_num_d;
`else
  localparam bit STALL_ON_PENDING = 1'b1;
`endif

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] rd_sync_q, rd_sync_d, wr_sync_q, wr_sync_d;
  logic                   emu_req_q, emu_req_d, emu_rnw_q, emu_rnw_d;
  logic                   cmem_rd_q, cmem_rd_d, cmem_wr_q, cmem_wr_d;
  logic [AW-1:0]          cp_address_q, cp_address_d;
  logic [DW-1:0]          cp_data_out_q, cp_data_out_d;
  logic                   rd_raw, wr_raw, rd_s, wr_s, any_s, ack_match, route_emu;
  logic [DW-1:0]          drive_val;

  assign rd_raw    = !CP_RTC_CS_n && !CP_RD_n;
  assign wr_raw    = !CP_RTC_CS_n && !CP_WR_n;
  assign rd_sync_d = {rd_sync_q[SYNC_STAGES-2:0], rd_raw};
  assign wr_sync_d = {wr_sync_q[SYNC_STAGES-2:0], wr_raw};
  assign rd_s      = rd_sync_q[SYNC_STAGES-1];
  assign wr_s      = wr_sync_q[SYNC_STAGES-1];
  assign any_s     = rd_s || wr_s;
  assign ack_match = (emu.emu_ack == emu_req_q);
  assign route_emu = !cmem_bank || BYPASS_MASK[cp_address_q];

  always_comb begin
    state_d       = state_q;
    emu_req_d     = emu_req_q;
    emu_rnw_d     = emu_rnw_q;
    cmem_rd_d     = 1'b0;
    cmem_wr_d     = 1'b0;
    cp_address_d  = cp_address_q;
    cp_data_out_d = cp_data_out_q;
`ifdef CP_ACK_TIMEOUT_EN
    to_cnt_d      = to_cnt_q;
    to_num_d      = to_num_q;
`endif
    case (state_q)
      S_IDLE: begin
        cp_address_d  = CP_A;
        cp_data_out_d = CP_D;
        if (any_s) state_d = S_LATCH;
      end
      S_LATCH: begin
        // A strobe that vanished before routing is treated as a glitch.
        if (!any_s) begin
          state_d = S_IDLE;
        end else if (route_emu) begin
          if (ack_match || !STALL_ON_PENDING) begin
            emu_req_d = !emu.emu_ack;
            emu_rnw_d = rd_s;
            state_d   = S_WAIT_EMU;
`ifdef CP_ACK_TIMEOUT_EN
            to_cnt_d  = '0;
`endif
          end
        end else begin
          cmem_rd_d = rd_s;
          cmem_wr_d = !rd_s;
          state_d   = S_WAIT_CMEM;
        end
      end
      S_WAIT_EMU: begin
        if (!any_s) begin
          state_d = S_IDLE;
`ifdef CP_ACK_TIMEOUT_EN
        end else if (!ack_match) begin
          if (to_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
            state_d = S_TIMEDOUT;
            if (to_num_q != 8'hFF) to_num_d = to_num_q + 8'd1;
          end else begin
            to_cnt_d = to_cnt_q + TW'(1);
          end
`endif
        end
      end
      S_WAIT_CMEM: if (!any_s) state_d = S_IDLE;
`ifdef CP_ACK_TIMEOUT_EN
      S_TIMEDOUT:  if (!any_s) state_d = S_IDLE;
`endif
      default:     state_d = S_IDLE;
    endcase
  end

  always_comb begin
    drive_val = '0;
    case (state_q)
      S_WAIT_CMEM: drive_val = cmem_rdata;
      S_WAIT_EMU:  drive_val = ack_match ? emu.emu_rdata : '0;
`ifdef CP_ACK_TIMEOUT_EN
      S_TIMEDOUT:  drive_val = TIMEOUT_DATA;
`endif
      default:     drive_val = '0;
    endcase
  end

  // Gating with reset_n releases the bus the instant reset asserts.
  assign cp_d_oe = rd_raw && reset_n;
  assign CP_D    = cp_d_oe ? drive_val : {DW{1'bz}};

  always_ff @(posedge clk200 or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      rd_sync_q     <= '0;
      wr_sync_q     <= '0;
      emu_req_q     <= 1'b0;
      emu_rnw_q     <= 1'b0;
      cmem_rd_q     <= 1'b0;
      cmem_wr_q     <= 1'b0;
      cp_address_q  <= '0;
      cp_data_out_q <= '0;
`ifdef CP_ACK_TIMEOUT_EN
      to_cnt_q      <= '0;
      to_num_q      <= '0;
`endif
    end else begin
      state_q       <= state_d;
      rd_sync_q     <= rd_sync_d;
      wr_sync_q     <= wr_sync_d;
      emu_req_q     <= emu_req_d;
      emu_rnw_q     <= emu_rnw_d;
      cmem_rd_q     <= cmem_rd_d;
      cmem_wr_q     <= cmem_wr_d;
      cp_address_q  <= cp_address_d;
      cp_data_out_q <= cp_data_out_d;
`ifdef CP_ACK_TIMEOUT_EN
      to_cnt_q      <= to_cnt_d;
      to_num_q      <= to_num_d;
`endif
    end
  end

  assign emu.emu_req  = emu_req_q;
  assign emu.emu_rnw  = emu_rnw_q;
  assign emu.emu_done = (state_q == S_WAIT_EMU) && ack_match;
  assign cmem_rd      = cmem_rd_q;
  assign cmem_wr      = cmem_wr_q;
  assign cp_address   = cp_address_q;
  assign cp_data_out  = cp_data_out_q;
  assign state_dbg    = state_q;
`ifdef CP_ACK_TIMEOUT_EN
  assign timeout_count = to_num_q;
`else
  assign timeout_count = 8'd0;
`endif

endmodule

// File: tb/tb_clock_port_bridge.sv
// Bench for clock_port_bridge: memory/emulator models, scoreboard of expected bus values.
module tb_clock_port_bridge;

  localparam logic [2:0] ST_IDLE = 3'd0, ST_LATCH = 3'd1, ST_WAIT_EMU = 3'd2,
                         ST_WAIT_CMEM = 3'd3, ST_TIMEDOUT = 3'd4;
  localparam logic [3:0] TO_DATA = 4'hC;

  logic       clk200 = 1'b0;
  logic       reset_n;
  logic       cs_n, rd_n, wr_n, cmem_bank;
  logic [3:0] cp_a;
  wire  [3:0] cp_d;
  logic [3:0] tb_d;
  logic       tb_d_oe;
  logic       cmem_rd, cmem_wr, cp_d_oe;
  logic [3:0] cmem_rdata, cp_address, cp_data_out;
  logic [7:0] timeout_count;
  logic [2:0] state_dbg;

  clock_port_bridge_if #(.DW(4)) emu_bus ();

  assign cp_d = tb_d_oe ? tb_d : 4'bz;

  clock_port_bridge #(
    .AW(4), .DW(4), .SYNC_STAGES(2), .BYPASS_MASK(16'h2000),
    .TIMEOUT_CYCLES(16), .TIMEOUT_DATA(TO_DATA)
  ) dut (
    .clk200(clk200), .reset_n(reset_n), .CP_RTC_CS_n(cs_n), .CP_RD_n(rd_n),
    .CP_WR_n(wr_n), .CP_A(cp_a), .CP_D(cp_d), .cmem_bank(cmem_bank),
    .emu(emu_bus), .cmem_rd(cmem_rd), .cmem_wr(cmem_wr), .cmem_rdata(cmem_rdata),
    .cp_address(cp_address), .cp_data_out(cp_data_out),
    .timeout_count(timeout_count), .cp_d_oe(cp_d_oe), .state_dbg(state_dbg)
  );

  // clock / watchdog
  always #5 clk200 = ~clk200;
  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  // clock-memory model
  logic [3:0] cmem_model [16];
  initial begin
    for (int i = 0; i < 16; i++) cmem_model[i] = 4'(i);
    cmem_model[3] = 4'hA;
    cmem_rdata = 4'h0;
  end
  always @(posedge clk200) begin
    if (cmem_rd) cmem_rdata <= cmem_model[cp_address];
    if (cmem_wr) cmem_model[cp_address] <= cp_data_out;
  end

  // emulator model: acks emu_delay cycles after a req toggle when enabled
  bit         emu_enable;
  int         emu_delay;
  logic [3:0] emu_data_next;
  int         pend;
  always @(negedge clk200) begin
    if (!reset_n) begin
      emu_bus.emu_ack   = 1'b0;
      emu_bus.emu_rdata = 4'h0;
      pend = 0;
    end else if (emu_enable && emu_bus.emu_req != emu_bus.emu_ack) begin
      pend++;
      if (pend >= emu_delay) begin
        emu_bus.emu_rdata = emu_data_next;
        emu_bus.emu_ack   = emu_bus.emu_req;
        pend = 0;
      end
    end else begin
      pend = 0;
    end
  end

  // monitor: strobe and toggle counts, pulse width, pulse position
  int         req_toggles, cmem_rd_cnt, cmem_wr_cnt, cmem_wide, cmem_misplaced;
  logic       last_req, last_rd, last_wr;
  logic [2:0] prev_state;
  initial begin
    req_toggles = 0; cmem_rd_cnt = 0; cmem_wr_cnt = 0; cmem_wide = 0; cmem_misplaced = 0;
    last_req = 0; last_rd = 0; last_wr = 0; prev_state = ST_IDLE;
    forever begin
      @(negedge clk200);
      if (emu_bus.emu_req !== last_req) req_toggles++;
      if (cmem_rd) cmem_rd_cnt++;
      if (cmem_wr) cmem_wr_cnt++;
      if ((cmem_rd && last_rd) || (cmem_wr && last_wr)) cmem_wide++;
      if ((cmem_rd || cmem_wr) && prev_state != ST_LATCH) cmem_misplaced++;
      last_req = emu_bus.emu_req; last_rd = cmem_rd; last_wr = cmem_wr;
      prev_state = state_dbg;
    end
  end

  // scoreboard
  int         checks = 0, errors = 0;
  logic [3:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_state(input logic [2:0] tgt, input int budget, input string tag,
                            output int waited);
    waited = 0;
    while (state_dbg != tgt && waited < budget) begin
      @(negedge clk200);
      waited++;
    end
    check(tag, 32'(state_dbg), 32'(tgt));
  endtask

  task automatic wait_done(input int budget, input string tag);
    int n = 0;
    while (!emu_bus.emu_done && n < budget) begin
      @(negedge clk200);
      n++;
    end
    check(tag, 32'(emu_bus.emu_done), 32'd1);
  endtask

  task automatic start_access(input bit is_rd, input logic [3:0] addr, input logic [3:0] wdata);
    cp_a = addr;
    if (!is_rd) begin
      tb_d    = wdata;
      tb_d_oe = 1'b1;
    end
    cs_n = 1'b0;
    if (is_rd) rd_n = 1'b0;
    else       wr_n = 1'b0;
  endtask

  task automatic end_access(input string tag);
    int w;
    cs_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1; tb_d_oe = 1'b0;
    #1 check({tag, "_release_oe"}, 32'(cp_d_oe), 32'd0);
    @(negedge clk200);
    wait_state(ST_IDLE, 10, {tag, "_idle"}, w);
  endtask

  task automatic read_txn(input logic [3:0] addr, input bit emu_route, input logic [3:0] exp,
                          input string tag);
    int w;
    start_access(1'b1, addr, 4'h0);
    exp_q.push_back(exp);
    if (emu_route) begin
      wait_state(ST_WAIT_EMU, 20, {tag, "_wait_emu"}, w);
      if (!emu_bus.emu_done) check({tag, "_pre_ack_d"}, 32'(cp_d), 32'd0);
      wait_done(40, {tag, "_done"});
      check({tag, "_rnw"}, 32'(emu_bus.emu_rnw), 32'd1);
    end else begin
      wait_state(ST_WAIT_CMEM, 20, {tag, "_wait_cmem"}, w);
      repeat (2) @(negedge clk200);
    end
    check({tag, "_oe"}, 32'(cp_d_oe), 32'd1);
    check({tag, "_data"}, 32'(cp_d), 32'(exp_q.pop_front()));
    end_access(tag);
  endtask

  int w, tog0, rd0, wr0;

  initial begin
    // reset
    reset_n = 1'b0; cs_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1; cp_a = 4'h0;
    tb_d = 4'h0; tb_d_oe = 1'b0; cmem_bank = 1'b1;
    emu_enable = 1'b1; emu_delay = 3; emu_data_next = 4'h0;
    repeat (3) @(negedge clk200);
    check("rst_state", 32'(state_dbg), 32'(ST_IDLE));
    check("rst_req", 32'(emu_bus.emu_req), 32'd0);
    check("rst_cmem", 32'({cmem_rd, cmem_wr}), 32'd0);
    check("rst_addr_data", 32'({cp_address, cp_data_out}), 32'd0);
    check("rst_tocount", 32'(timeout_count), 32'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk200);

    // clock-memory read of address 3
    rd0 = cmem_rd_cnt; tog0 = req_toggles;
    read_txn(4'h3, 1'b0, 4'hA, "cmem_rd3");
    check("cmem_rd3_pulses", 32'(cmem_rd_cnt - rd0), 32'd1);
    check("cmem_rd3_no_req", 32'(req_toggles - tog0), 32'd0);

    // bypass address 0xD goes to emulator even with cmem_bank=1
    wr0 = cmem_wr_cnt; tog0 = req_toggles;
    start_access(1'b0, 4'hD, 4'h5);
    exp_q.push_back(4'h5);
    wait_state(ST_WAIT_EMU, 20, "byp_wait_emu", w);
    check("byp_rnw", 32'(emu_bus.emu_rnw), 32'd0);
    check("byp_addr", 32'(cp_address), 32'hD);
    check("byp_wdata", 32'(cp_data_out), 32'(exp_q.pop_front()));
    wait_done(20, "byp_done");
    end_access("byp");
    check("byp_toggles", 32'(req_toggles - tog0), 32'd1);
    check("byp_no_cmem_wr", 32'(cmem_wr_cnt - wr0), 32'd0);

    // clock-memory write then read-back of address 6
    wr0 = cmem_wr_cnt;
    start_access(1'b0, 4'h6, 4'h3);
    wait_state(ST_WAIT_CMEM, 20, "cmw_wait", w);
    repeat (2) @(negedge clk200);
    end_access("cmw");
    check("cmw_pulses", 32'(cmem_wr_cnt - wr0), 32'd1);
    read_txn(4'h6, 1'b0, 4'h3, "cmw_readback");

    // emulator read with slow ack
    cmem_bank = 1'b0; emu_delay = 10; emu_data_next = 4'h7;
    read_txn(4'h2, 1'b1, 4'h7, "emu_rd2");

    // short glitch: no request, no memory strobe
    tog0 = req_toggles; rd0 = cmem_rd_cnt;
    cs_n = 1'b0; rd_n = 1'b0;
    @(negedge clk200);
    cs_n = 1'b1; rd_n = 1'b1;
    repeat (8) @(negedge clk200);
    check("glitch_state", 32'(state_dbg), 32'(ST_IDLE));
    check("glitch_req", 32'(req_toggles - tog0), 32'd0);
    check("glitch_cmem", 32'(cmem_rd_cnt - rd0), 32'd0);

`ifdef CP_ACK_TIMEOUT_EN
    // ack never returns: timeout after 16 cycles
    emu_enable = 1'b0;
    start_access(1'b1, 4'h2, 4'h0);
    exp_q.push_back(TO_DATA);
    wait_state(ST_WAIT_EMU, 20, "to_wait_emu", w);
    wait_state(ST_TIMEDOUT, 40, "to_timedout", w);
    check("to_cycles", 32'(w), 32'd16);
    check("to_data", 32'(cp_d), 32'(exp_q.pop_front()));
    check("to_count", 32'(timeout_count), 32'd1);
    end_access("to");
    emu_delay = 3; emu_data_next = 4'h6; emu_enable = 1'b1;
    repeat (6) @(negedge clk200);
    tog0 = req_toggles;
    read_txn(4'h2, 1'b1, 4'h6, "to_next");
    check("to_next_toggle", 32'(req_toggles - tog0), 32'd1);
`else
    // pending ack stalls the next emulator access in LATCH
    emu_enable = 1'b0;
    start_access(1'b0, 4'h1, 4'h4);
    wait_state(ST_WAIT_EMU, 20, "stall_wr", w);
    end_access("stall_wr");
    tog0 = req_toggles;
    start_access(1'b1, 4'h2, 4'h0);
    repeat (10) @(negedge clk200);
    check("stall_state", 32'(state_dbg), 32'(ST_LATCH));
    check("stall_no_toggle", 32'(req_toggles - tog0), 32'd0);
    emu_delay = 2; emu_data_next = 4'h3; emu_enable = 1'b1;
    exp_q.push_back(4'h3);
    wait_state(ST_WAIT_EMU, 20, "stall_resume", w);
    wait_done(20, "stall_done");
    check("stall_data", 32'(cp_d), 32'(exp_q.pop_front()));
    end_access("stall_rd");
    check("stall_toggle", 32'(req_toggles - tog0), 32'd1);
`endif

    // reset during an emulator read wait
    emu_enable = 1'b0;
    start_access(1'b1, 4'h5, 4'h0);
    wait_state(ST_WAIT_EMU, 20, "rst_mid_wait", w);
    reset_n = 1'b0;
    #1;
    check("rst_mid_oe", 32'(cp_d_oe), 32'd0);
    check("rst_mid_state", 32'(state_dbg), 32'(ST_IDLE));
    check("rst_mid_outs", 32'({emu_bus.emu_req, emu_bus.emu_rnw, emu_bus.emu_done,
                               cmem_rd, cmem_wr, cp_address, cp_data_out, timeout_count}), 32'd0);
    repeat (2) @(negedge clk200);
    cs_n = 1'b1; rd_n = 1'b1;
    reset_n = 1'b1;
    emu_delay = 3; emu_data_next = 4'h9; emu_enable = 1'b1;
    repeat (4) @(negedge clk200);
    tog0 = req_toggles;
    read_txn(4'h1, 1'b1, 4'h9, "post_rst");
    check("post_rst_toggle", 32'(req_toggles - tog0), 32'd1);

    check("cmem_pulse_width", 32'(cmem_wide), 32'd0);
    check("cmem_after_latch", 32'(cmem_misplaced), 32'd0);
    check("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/clock_port_bridge.md
Name: clock_port_bridge

Overview:
- Parametrised successor of the RTC clock-port front end: samples the Amiga clock-port strobes and latches address and data.
- Routes each access either to local clock memory (single-cycle strobe) or to the emulator (toggle req/ack handshake with an rd/wr qualifier).
- Drives read data back onto the bidirectional clock-port data bus.
- Adds generic address/data widths, configurable sync depth, a configurable set of bypass addresses that always go to the emulator, an emulator-completion flag, and an optional ack timeout.

Parameters:
- AW, 4, clock-port address width (CP_A[AW+1:2]).
- DW, 4, clock-port data width.
- SYNC_STAGES, 2, synchroniser flops on rd/wr strobes (legal 2..4).
- BYPASS_MASK, 16'h2000, bit i set = address i always routed to emulator even when cmem_bank=1 (only the low 2**AW bits used).
- TIMEOUT_CYCLES, 1024, clk200 cycles allowed in WAIT_EMU (only with CP_ACK_TIMEOUT_EN).
- TIMEOUT_DATA, 0, read data returned on timeout (DW bits).

Ports:
- clk200  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- CP_RTC_CS_n  in  1  clock-port chip select, async.
- CP_RD_n  in  1  read strobe, async.
- CP_WR_n  in  1  write strobe, async.
- CP_A  in  AW  address bits [AW+1:2].
- CP_D  inout  DW  data bus.
- cmem_bank  in  1  1 = non-bypass addresses go to clock memory.
- emu_req  out  1  toggles once per emulator access.
- emu_rnw  out  1  1 = read; valid from the emu_req toggle until the matching ack.
- emu_ack  in  1  emulator completes when emu_ack == emu_req.
- emu_rdata  in  DW  emulator read data; valid once ack matches.
- cmem_rd  out  1  one-cycle read strobe.
- cmem_wr  out  1  one-cycle write strobe.
- cmem_rdata  in  DW  clock-memory read data; valid the cycle after cmem_rd.
- cp_address  out  AW  latched address.
- cp_data_out  out  DW  latched write data.
- emu_done  out  1  high while WAIT_EMU holds with ack matched.
- timeout_count  out  8  saturating count of timed-out accesses (0 when the feature is absent).

Behaviour:
- Reset values: all outputs 0; state IDLE; synchronisers 0.
- Strobe decode (combinational): rd = !CS_n & !RD_n; wr = !CS_n & !WR_n.
  - rd and wr pass through SYNC_STAGES flops to give rd_s and wr_s.
- IDLE:
  - Every cycle, cp_address <= CP_A and cp_data_out <= CP_D.
  - When rd_s | wr_s, go to LATCH. Latches therefore hold values sampled SYNC_STAGES cycles after strobe assertion.
- LATCH:
  - route_emu = !cmem_bank | BYPASS_MASK[cp_address].
  - rd_s has priority if both strobes are high.
  - Emulator route: emu_req <= !emu_ack, emu_rnw <= rd_s, go to WAIT_EMU.
  - Memory route: pulse cmem_rd or cmem_wr for exactly one cycle, go to WAIT_CMEM.
- WAIT_EMU:
  - When emu_ack == emu_req: emu_done = 1; stays in WAIT_EMU.
  - When rd_s = wr_s = 0: go to IDLE, whether or not ack has arrived.
  - A late ack is tolerated. A new access is not issued while ack != req; LATCH stalls until they match.
- WAIT_CMEM: exits to IDLE when both synchronised strobes are low.
- Bus drive:
  - CP_D is driven only while the raw rd is high; otherwise high-Z.
  - WAIT_CMEM drives cmem_rdata.
  - WAIT_EMU drives emu_rdata if ack matches, else 0.
  - TIMEDOUT drives TIMEOUT_DATA.
  - Any other state drives 0.
- Strobe dropping before LATCH (glitch shorter than the sync depth): the FSM returns to IDLE with no req and no strobe.
- Reset mid-access returns to IDLE and releases CP_D immediately. emu_req resets to 0; the emulator side must also reset its ack.
- Illegal state encodings go to IDLE.

Optional Feature:
- Macro CP_ACK_TIMEOUT_EN.
- When defined:
  - A counter runs in WAIT_EMU while ack != req.
  - When it reaches TIMEOUT_CYCLES, go to TIMEDOUT and increment timeout_count (saturating at 255).
  - TIMEDOUT exits to IDLE when the strobes are released.
  - The next LATCH does not stall on ack mismatch; it re-toggles req relative to the current ack.
- When undefined:
  - No counter and no TIMEDOUT state; timeout_count ties to 0.
  - WAIT_EMU may wait indefinitely for ack while the strobe is held.

Test Plan:
- cmem_bank=1, read addr 3: cmem_rd pulses 1 cycle after LATCH; cmem_rdata=4'hA appears on CP_D while RD_n is low; high-Z after release.
- cmem_bank=1, write addr 4'hD with data 4'h5: emu_req toggles, emu_rnw=0, cp_data_out=5; no cmem_wr pulse.
- cmem_bank=0, read addr 2, ack returned 10 cycles later with emu_rdata=4'h7: CP_D=0 until ack, then 7; emu_done=1.
- 1-cycle CS/RD glitch with SYNC_STAGES=2: no req toggle, no cmem strobe, state back to IDLE.
- CP_ACK_TIMEOUT_EN, TIMEOUT_CYCLES=16, ack never returned, read held: after 16 cycles CP_D=TIMEOUT_DATA and timeout_count=1; the next access toggles req again.
- reset_n asserted during WAIT_EMU read: CP_D high-Z in the same cycle; all outputs 0; a following access completes normally.
